// File: rtl/id_stage.sv
// RV32 decode stage: combinational decode of the fetched word into a registered ID/EX slot,
// with load-use bubble insertion, flush and a saturating bubble counter.
module id_stage #(
    parameter int WORD_BITWIDTH    = 32,
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int CNT_BITWIDTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_BITWIDTH-1:0]    in_instruction,
    input  logic [WORD_BITWIDTH-1:0]    in_pc,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_BITWIDTH-1:0]    out_pc,
    output logic [WORD_BITWIDTH-1:0]    out_imm,
    output logic [REG_NUM_BITWIDTH-1:0] out_rs1,
    output logic [REG_NUM_BITWIDTH-1:0] out_rs2,
    output logic [REG_NUM_BITWIDTH-1:0] out_rd,
    output logic                        out_branch,
    output logic                        out_jump,
    output logic                        out_memRead,
    output logic                        out_memToReg,
    output logic                        out_memWrite,
    output logic                        out_ALUSrc,
    output logic                        out_regWrite,
    output logic                        out_illegal,
    output logic [1:0]                  out_ALUOp,
    output logic [CNT_BITWIDTH-1:0]     bubble_count
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [6:0]                  opcode;
    logic [REG_NUM_BITWIDTH-1:0] rs1, rs2, rd;
    logic [WORD_BITWIDTH-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [WORD_BITWIDTH-1:0]    d_imm;
    logic                        d_branch, d_jump, d_mem_read, d_mem_to_reg;
    logic                        d_mem_write, d_alu_src, d_reg_write, d_illegal;
    logic [1:0]                  d_alu_op;
    logic                        rs1_used, rs2_used;
    logic                        hazard, accept;

    assign opcode = in_instruction[6:0];
    assign rs1    = in_instruction[15 +: REG_NUM_BITWIDTH];
    assign rs2    = in_instruction[20 +: REG_NUM_BITWIDTH];
    assign rd     = in_instruction[7 +: REG_NUM_BITWIDTH];

    assign imm_i = WORD_BITWIDTH'($signed(in_instruction[31:20]));
    assign imm_s = WORD_BITWIDTH'($signed({in_instruction[31:25], in_instruction[11:7]}));
    assign imm_b = WORD_BITWIDTH'($signed({in_instruction[31], in_instruction[7],
                                           in_instruction[30:25], in_instruction[11:8], 1'b0}));
    assign imm_u = WORD_BITWIDTH'($signed({in_instruction[31:12], 12'b0}));
    assign imm_j = WORD_BITWIDTH'($signed({in_instruction[31], in_instruction[19:12],
                                           in_instruction[20], in_instruction[30:21], 1'b0}));

    always_comb begin
        d_branch     = 1'b0;
        d_jump       = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_to_reg = 1'b0;
        d_mem_write  = 1'b0;
        d_alu_src    = 1'b0;
        d_reg_write  = 1'b0;
        d_illegal    = 1'b0;
        d_alu_op     = 2'b00;
        d_imm        = '0;
        rs1_used     = 1'b1;
        rs2_used     = 1'b0;
        case (opcode)
            OP_R: begin
                d_reg_write = 1'b1;
                d_alu_op    = 2'b10;
                rs2_used    = 1'b1;
            end
            OP_IMM: begin
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
                d_alu_op    = 2'b11;
                d_imm       = imm_i;
            end
            OP_LOAD: begin
                d_mem_read   = 1'b1;
                d_mem_to_reg = 1'b1;
                d_alu_src    = 1'b1;
                d_reg_write  = 1'b1;
                d_imm        = imm_i;
            end
            OP_STORE: begin
                d_mem_write = 1'b1;
                d_alu_src   = 1'b1;
                d_imm       = imm_s;
                rs2_used    = 1'b1;
            end
            OP_BRANCH: begin
                d_branch = 1'b1;
                d_alu_op = 2'b01;
                d_imm    = imm_b;
                rs2_used = 1'b1;
            end
            OP_JAL: begin
                d_jump      = 1'b1;
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
                d_imm       = imm_j;
                rs1_used    = 1'b0;
            end
            OP_JALR: begin
                d_jump      = 1'b1;
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
                d_imm       = imm_i;
            end
            OP_LUI, OP_AUIPC: begin
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
                d_imm       = imm_u;
                rs1_used    = 1'b0;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // in_ready never depends on in_valid except through the load-use hazard term.
    assign hazard = in_valid & out_valid & out_memRead & (out_rd != '0) &
                    ((rs1_used & (out_rd == rs1)) | (rs2_used & (out_rd == rs2)));
    assign in_ready = (!out_valid | out_ready) & !hazard & !flush;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_imm      <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rd       <= '0;
            out_branch   <= 1'b0;
            out_jump     <= 1'b0;
            out_memRead  <= 1'b0;
            out_memToReg <= 1'b0;
            out_memWrite <= 1'b0;
            out_ALUSrc   <= 1'b0;
            out_regWrite <= 1'b0;
            out_illegal  <= 1'b0;
            out_ALUOp    <= 2'b00;
            bubble_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_imm      <= d_imm;
            out_rs1      <= rs1;
            out_rs2      <= rs2;
            out_rd       <= rd;
            out_branch   <= d_branch;
            out_jump     <= d_jump;
            out_memRead  <= d_mem_read;
            out_memToReg <= d_mem_to_reg;
            out_memWrite <= d_mem_write;
            out_ALUSrc   <= d_alu_src;
            out_regWrite <= d_reg_write;
            out_illegal  <= d_illegal;
            out_ALUOp    <= d_alu_op;
        end else if (hazard && out_ready) begin
            out_valid <= 1'b0;
            if (bubble_count != '1) begin
                bubble_count <= bubble_count + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
        // Otherwise the slot is stalled (or empty) and every field holds.
    end
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: decode vector table, hand-written load-use/stall/flush/reset sequences,
// and a randomized run against a cycle-level reference model.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instruction, in_pc, out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_branch, out_jump, out_memRead, out_memToReg, out_memWrite;
    logic        out_ALUSrc, out_regWrite, out_illegal;
    logic [1:0]  out_ALUOp;
    logic [15:0] bubble_count;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_pc, s_out_imm;
    logic [4:0]  s_out_rs1, s_out_rs2, s_out_rd;
    logic        s_b, s_j, s_mr, s_mtr, s_mw, s_as, s_rw, s_il;
    logic [1:0]  s_op;
    logic [1:0]  s_bubble_count;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_branch(out_branch), .out_jump(out_jump), .out_memRead(out_memRead),
        .out_memToReg(out_memToReg), .out_memWrite(out_memWrite), .out_ALUSrc(out_ALUSrc),
        .out_regWrite(out_regWrite), .out_illegal(out_illegal), .out_ALUOp(out_ALUOp),
        .bubble_count(bubble_count)
    );

    // Narrow-counter copy, used only to observe counter saturation.
    id_stage #(.CNT_BITWIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_imm(s_out_imm),
        .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_rd(s_out_rd),
        .out_branch(s_b), .out_jump(s_j), .out_memRead(s_mr), .out_memToReg(s_mtr),
        .out_memWrite(s_mw), .out_ALUSrc(s_as), .out_regWrite(s_rw), .out_illegal(s_il),
        .out_ALUOp(s_op), .bubble_count(s_bubble_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [7:0]  ctrl;     // branch,jump,memRead,memToReg,memWrite,ALUSrc,regWrite,illegal
        logic [1:0]  alu_op;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic [1:0]  alu_op;
    } vec_t;

    dec_t        dut_rec;
    logic [7:0]  dut_ctrl;
    int          checks = 0;
    int          failures = 0;

    assign dut_ctrl = {out_branch, out_jump, out_memRead, out_memToReg, out_memWrite,
                       out_ALUSrc, out_regWrite, out_illegal};
    assign dut_rec  = '{pc: out_pc, imm: out_imm, rs1: out_rs1, rs2: out_rs2, rd: out_rd,
                        ctrl: dut_ctrl, alu_op: out_ALUOp};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference decode from the instruction-set rules, immediates built arithmetically.
    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        dec_t d;
        int   s;
        int   imm;
        s = $signed(ins);
        imm = 0;
        d = '0;
        d.pc  = pc;
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        d.rd  = ins[11:7];
        case (ins[6:0])
            7'h33: begin d.ctrl = 8'b0000_0010; d.alu_op = 2'b10; end
            7'h13: begin d.ctrl = 8'b0000_0110; d.alu_op = 2'b11; imm = s >>> 20; end
            7'h03: begin d.ctrl = 8'b0011_0110; imm = s >>> 20; end
            7'h23: begin d.ctrl = 8'b0000_1100; imm = (s >>> 25) * 32 + int'(ins[11:7]); end
            7'h63: begin
                d.ctrl = 8'b1000_0000; d.alu_op = 2'b01;
                imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                      + int'(ins[11:8]) * 2;
            end
            7'h6F: begin
                d.ctrl = 8'b0100_0110;
                imm = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                      + int'(ins[30:21]) * 2;
            end
            7'h67: begin d.ctrl = 8'b0100_0110; imm = s >>> 20; end
            7'h37, 7'h17: begin d.ctrl = 8'b0000_0110; imm = (s >>> 12) * 4096; end
            default: d.ctrl = 8'b0000_0001;
        endcase
        d.imm = 32'(imm);
        return d;
    endfunction

    function automatic bit uses_rs1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return (op == 7'h33 || op == 7'h23 || op == 7'h63);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h6F,
                                   7'h67, 7'h37, 7'h17, 7'h7F};
        r = $urandom;
        r[6:0]   = ops[$urandom_range(0, 10)];
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    // One clock: in_ready is checked mid-cycle, registered outputs are observed #1 after the edge.
    task automatic step(input logic exp_ready, input string nm);
        @(negedge clk);
        chk(nm, 128'(in_ready), 128'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_LW   = 32'h0001_2283;
    localparam logic [31:0] I_ADD  = 32'h0012_8333;
    localparam logic [31:0] I_ADDI = 32'hFFF0_0093;
    localparam logic [31:0] I_LUI  = 32'h1234_50B7;

    vec_t vecs [10];
    dec_t m_out;
    bit   m_valid;
    int   m_bub;
    bit   hz, exp_rdy;

    initial begin
        vecs[0] = '{32'hFFF0_0093, 32'hFFFF_FFFF, 8'b0000_0110, 2'b11};  // ADDI x1,x0,-1
        vecs[1] = '{32'h0080_00EF, 32'h0000_0008, 8'b0100_0110, 2'b00};  // JAL x1,+8
        vecs[2] = '{32'h1234_50B7, 32'h1234_5000, 8'b0000_0110, 2'b00};  // LUI x1,0x12345
        vecs[3] = '{32'h0000_007F, 32'h0000_0000, 8'b0000_0001, 2'b00};  // illegal
        vecs[4] = '{32'h0001_2283, 32'h0000_0000, 8'b0011_0110, 2'b00};  // LW x5,0(x2)
        vecs[5] = '{32'h0012_8333, 32'h0000_0000, 8'b0000_0010, 2'b10};  // ADD x6,x5,x1
        vecs[6] = '{32'hFE51_2E23, 32'hFFFF_FFFC, 8'b0000_1100, 2'b00};  // SW x5,-4(x2)
        vecs[7] = '{32'hFE20_88E3, 32'hFFFF_FFF0, 8'b1000_0000, 2'b01};  // BEQ x1,x2,-16
        vecs[8] = '{32'hFFFF_F197, 32'hFFFF_F000, 8'b0000_0110, 2'b00};  // AUIPC x3,0xFFFFF
        vecs[9] = '{32'h0041_00E7, 32'h0000_0004, 8'b0100_0110, 2'b00};  // JALR x1,4(x2)

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instruction = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_fields", 128'(dut_rec), 128'(0));
        chk("reset_valid", 128'(out_valid), 128'(0));
        chk("reset_bubbles", 128'(bubble_count), 128'(0));

        // Load-use: LW then dependent ADD.
        in_valid = 1'b1; in_instruction = I_LW; in_pc = 32'h100;
        step(1'b1, "lw_ready_after_reset");
        chk("lw_rec", 128'(dut_rec), 128'(ref_decode(I_LW, 32'h100)));
        in_instruction = I_ADD; in_pc = 32'h104;
        step(1'b0, "loaduse_ready_low");
        chk("bubble_valid", 128'(out_valid), 128'(0));
        chk("bubble_count_1", 128'(bubble_count), 128'(1));
        step(1'b1, "loaduse_ready_back");
        chk("add_valid", 128'(out_valid), 128'(1));
        chk("add_rec", 128'(dut_rec), 128'(ref_decode(I_ADD, 32'h104)));
        in_valid = 1'b0;
        step(1'b1, "idle_after_add");
        chk("drain_valid", 128'(out_valid), 128'(0));

        // Decode table, one instruction at a time with an idle gap.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_instruction = vecs[i].instr; in_pc = 32'(i * 4);
            step(1'b1, "table_ready");
            chk($sformatf("table_valid[%0d]", i), 128'(out_valid), 128'(1));
            chk($sformatf("table_imm[%0d]", i), 128'(out_imm), 128'(vecs[i].imm));
            chk($sformatf("table_ctrl[%0d]", i), 128'(dut_ctrl), 128'(vecs[i].ctrl));
            chk($sformatf("table_aluop[%0d]", i), 128'(out_ALUOp), 128'(vecs[i].alu_op));
            chk($sformatf("table_rd[%0d]", i), 128'(out_rd), 128'(vecs[i].instr[11:7]));
            in_valid = 1'b0;
            step(1'b1, "table_gap");
        end

        // Back-pressure for 3 cycles, then flush.
        in_valid = 1'b1; in_instruction = I_ADDI; in_pc = 32'h200;
        step(1'b1, "stall_load");
        in_instruction = I_LUI; in_pc = 32'h204; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, "stall_ready_low");
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_hold", 128'(dut_rec), 128'(ref_decode(I_ADDI, 32'h200)));
        end
        flush = 1'b1;
        step(1'b0, "flush_ready_low");
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_bubbles", 128'(bubble_count), 128'(1));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        // Randomized run against the reference model.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_valid = 0; m_out = '0; m_bub = 0;
        for (int c = 0; c < 3000; c++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            in_instruction = rand_instr();
            in_pc          = $urandom;
            out_ready      = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 15) == 0);
            hz = in_valid && m_valid && m_out.ctrl[5] && (m_out.rd != 0) &&
                 ((uses_rs1(in_instruction[6:0]) && m_out.rd == in_instruction[19:15]) ||
                  (uses_rs2(in_instruction[6:0]) && m_out.rd == in_instruction[24:20]));
            exp_rdy = (!m_valid || out_ready) && !hz && !flush;
            step(exp_rdy, "rand_ready");
            if (flush) m_valid = 0;
            else if (in_valid && exp_rdy) begin
                m_out = ref_decode(in_instruction, in_pc);
                m_valid = 1;
            end else if (hz && out_ready) begin
                m_valid = 0;
                m_bub++;
            end else if (out_ready) m_valid = 0;
            chk("rand_valid", 128'(out_valid), 128'(m_valid));
            chk("rand_bubbles", 128'(bubble_count), 128'((m_bub > 65535) ? 65535 : m_bub));
            chk("rand_bubbles_sat", 128'(s_bubble_count), 128'((m_bub > 3) ? 3 : m_bub));
            if (m_valid) chk("rand_rec", 128'(dut_rec), 128'(m_out));
        end
        flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        step(1'b1, "rand_drain");

        // Reset during a load-use stall.
        in_valid = 1'b1; in_instruction = I_LW; in_pc = 32'h300;
        step(1'b1, "rst_seq_lw");
        in_instruction = I_ADD; out_ready = 1'b0; rst = 1'b1;
        step(1'b0, "rst_seq_stalled");
        chk("rst_stall_fields", 128'(dut_rec), 128'(0));
        chk("rst_stall_valid", 128'(out_valid), 128'(0));
        chk("rst_stall_bubbles", 128'(bubble_count), 128'(0));
        rst = 1'b0; in_valid = 1'b0;
        step(1'b1, "ready_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter WORD_BITWIDTH, default 32, instruction/immediate/PC width.
REQ-002 SHALL have parameter REG_NUM_BITWIDTH, default 5, register index width.
REQ-003 SHALL have parameter CNT_BITWIDTH, default 16, bubble counter width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  fetch presents an instruction.
REQ-008 in_ready  out  1  stage accepts the instruction this cycle.
REQ-009 in_instruction, in_pc  in  WORD_BITWIDTH  instruction word and its PC.
REQ-010 flush  in  1  branch redirect; kill stage contents.
REQ-011 out_valid  out  1  ID/EX register holds a live instruction.
REQ-012 out_ready  in  1  execute consumes the output this cycle.
REQ-013 out_pc, out_imm  out  WORD_BITWIDTH  registered PC and sign-extended immediate.
REQ-014 out_rs1, out_rs2, out_rd  out  REG_NUM_BITWIDTH  fields [19:15], [24:20], [11:7].
REQ-015 out_branch, out_jump, out_memRead, out_memToReg, out_memWrite, out_ALUSrc, out_regWrite, out_illegal  out  1 each  registered control.
REQ-016 out_ALUOp  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type arithmetic.
REQ-017 bubble_count  out  CNT_BITWIDTH  saturating count of inserted load-use bubbles.

Function
REQ-018 Decode SHALL be combinational on in_instruction; all outputs SHALL be registered, latency 1 cycle from accept.
REQ-019 Opcodes/control (branch,jump,memRead,memToReg,memWrite,ALUSrc,regWrite,ALUOp): 0110011 R 0,0,0,0,0,0,1,10; 0010011 I-imm 0,0,0,0,0,1,1,11; 0000011 load 0,0,1,1,0,1,1,00; 0100011 store 0,0,0,0,1,1,0,00; 1100011 branch 1,0,0,0,0,0,0,01; 1101111 JAL and 1100111 JALR 0,1,0,0,0,1,1,00; 0110111 LUI and 0010111 AUIPC 0,0,0,0,0,1,1,00.
REQ-020 Immediates SHALL be sign-extended from bit 31: I {[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; R imm SHALL be 0.
REQ-021 Any other opcode SHALL set out_illegal=1 with all other control bits 0 and imm 0; out_valid still asserted.
REQ-022 rs1 used by all except LUI, AUIPC, JAL; rs2 used only by R, store, branch.
REQ-023 hazard = in_valid & out_valid & out_memRead & (out_rd!=0) & ((rs1 used & out_rd==rs1) | (rs2 used & out_rd==rs2)).
REQ-024 in_ready SHALL equal (!out_valid | out_ready) & !hazard & !flush.
REQ-025 On accept (in_valid & in_ready) output register SHALL load decoded fields and out_valid=1.
REQ-026 If hazard & out_ready: out_valid SHALL become 0 (bubble), bubble_count +1 saturating at all-ones; held instruction SHALL be accepted next cycle.
REQ-027 If out_valid & !out_ready: output register SHALL hold every field unchanged.
REQ-028 If out_ready & no accept & no hazard: out_valid SHALL become 0.
REQ-029 flush SHALL have priority: next cycle out_valid=0, input dropped, bubble_count unchanged.
REQ-030 Fields other than out_valid need not clear on bubble/flush; consumers SHALL qualify with out_valid.

Reset
REQ-031 rst SHALL set out_valid, all control bits, out_imm, out_pc, out_rs1/rs2/rd and bubble_count to 0 on the next edge, overriding flush and accept, including mid-stall.
REQ-032 in_ready SHALL be 1 in the cycle after reset deassert (out_valid=0, no hazard).

Verification
REQ-033 ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_rd=1, ALUOp=11, ALUSrc=1, regWrite=1.
REQ-034 LW x5,0(x2) (0x00012283) then ADD x6,x5,x1 (0x00128333) back-to-back -> one cycle in_ready=0, one bubble, bubble_count=1, ADD emerges one cycle later.
REQ-035 JAL x1,+8 (0x008000EF) -> out_imm=8, out_jump=1, rd=1; LUI x1,0x12345 (0x123450B7) -> out_imm=0x12345000.
REQ-036 out_ready=0 for 3 cycles with valid output -> fields stable, in_ready=0; flush asserted -> out_valid=0 next cycle.
REQ-037 Opcode 0x7F -> out_illegal=1, regWrite=0, imm=0; rst asserted during load-use stall -> all outputs 0, bubble_count=0.
